// File: rtl/rdma_host_trailer_inserter_pkg.sv
// Shared definitions for the RDMA host trailer inserter: trailer field layout,
// default magic word and FSM states.
package rdma_host_trailer_inserter_pkg;

    localparam logic [31:0] DEF_TRAILER_MAGIC = 32'hC0DE_7A11;

    // Trailer layout inside the last beat's data word; every other bit is zero.
    localparam int TRL_MAGIC_LSB = 0;
    localparam int TRL_BEATS_LSB = 32;
    localparam int TRL_SEQ_LSB   = 48;
    localparam int TRL_BYTES_LSB = 64;
    localparam int TRL_ERR_BIT   = 96;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } state_t;

endpackage

// File: rtl/rdma_host_trailer_inserter_if.sv
// AXI4-Stream bundle used on both the RDMA sink side and the host source side.
interface rdma_host_trailer_inserter_if #(
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 6
);
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic [ID_BITS-1:0]     tid;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tdata, tkeep, tid, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tid, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/rdma_host_trailer_inserter_keep_popcount.sv
// Counts the set bits of a tkeep vector; purely combinational, synthesis
// balances the accumulation into an adder tree.
module keep_popcount #(
    parameter int KEEP_BITS = 64,
    parameter int CNT_BITS  = $clog2(KEEP_BITS + 1)
) (
    input  logic [KEEP_BITS-1:0] keep,
    output logic [CNT_BITS-1:0]  count
);

    always_comb begin
        // NOTE: assign every always_comb output a default first, otherwise a path that skips it infers a latch.
        count = '0;
        for (int i = 0; i < KEEP_BITS; i++) begin
            count = count + CNT_BITS'(keep[i]);
        end
    end

endmodule

// File: rtl/rdma_host_trailer_inserter.sv
// Network-to-host stream stage: passes payload through and replaces each packet's
// last beat with a trailer, truncating packets longer than MAX_BEATS.
module rdma_host_trailer_inserter
    import rdma_host_trailer_inserter_pkg::*;
#(
    parameter int          DATA_BITS     = 512,
    parameter int          ID_BITS       = 6,
    parameter int          MAX_BEATS     = 1024,
    parameter logic [31:0] TRAILER_MAGIC = DEF_TRAILER_MAGIC
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               enable,
    rdma_host_trailer_inserter_if.slave        s,
    rdma_host_trailer_inserter_if.master       m,
    output logic [31:0]                        pkt_count,
    output logic [15:0]                        trunc_count
);

    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int CNT_BITS  = $clog2(KEEP_BITS + 1);

    state_t               state_q, state_d;
    logic                 mode_q;
    logic [15:0]          beat_cnt_q;
    logic [31:0]          byte_cnt_q;
    logic [15:0]          pkt_seq_q;
    logic [CNT_BITS-1:0]  keep_ones;

    logic                 accept, out_hs_last, cur_mode, forced_last, emit_last, load_out;
    logic [15:0]          beats_now, seq_now;
    logic [31:0]          bytes_now;
    logic [DATA_BITS-1:0] out_data;
    logic [KEEP_BITS-1:0] out_keep;
    logic [ID_BITS-1:0]   out_tid;
    logic                 out_last;

    keep_popcount #(.KEEP_BITS(KEEP_BITS), .CNT_BITS(CNT_BITS)) u_keep_popcount (
        .keep  (s.tkeep),
        .count (keep_ones)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !s.tlast) state_d = IN_PKT;
            IN_PKT: begin
                if (accept && s.tlast)            state_d = IDLE;
                else if (accept && forced_last)   state_d = DROP;
            end
            DROP:    if (accept && s.tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s.tready    = (state_q == DROP) || !m.tvalid || m.tready;
        accept      = s.tvalid && s.tready;
        out_hs_last = m.tvalid && m.tready && m.tlast;
        cur_mode    = (state_q == IDLE) ? enable : mode_q;
        beats_now   = (state_q == IDLE) ? 16'd1 : beat_cnt_q + 16'd1;
        bytes_now   = ((state_q == IDLE) ? 32'd0 : byte_cnt_q) + 32'(keep_ones);
        // A last beat leaving this cycle has already consumed the current sequence number.
        seq_now     = pkt_seq_q + 16'(out_hs_last);
        forced_last = (state_q == IN_PKT) && mode_q && !s.tlast
                      && (beats_now == 16'(MAX_BEATS));
        emit_last   = s.tlast || forced_last;
        load_out    = accept && (state_q != DROP);

        out_data = s.tdata;
        out_keep = s.tkeep;
        out_tid  = s.tid;
        out_last = emit_last;
        if (cur_mode && emit_last) begin
            out_data                         = '0;
            out_data[TRL_MAGIC_LSB +: 32]    = TRAILER_MAGIC;
            out_data[TRL_BEATS_LSB +: 16]    = beats_now;
            out_data[TRL_SEQ_LSB +: 16]      = seq_now;
            out_data[TRL_BYTES_LSB +: 32]    = bytes_now;
            out_data[TRL_ERR_BIT]            = forced_last;
            out_keep                         = '1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: the datapath flops are reset too, so m_* read as zero while aresetn is low.
        if (!aresetn) begin
            m.tvalid    <= 1'b0;
            m.tdata     <= '0;
            m.tkeep     <= '0;
            m.tid       <= '0;
            m.tlast     <= 1'b0;
            mode_q      <= 1'b0;
            beat_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            pkt_seq_q   <= '0;
            pkt_count   <= '0;
            trunc_count <= '0;
        end else begin
            if (load_out) begin
                m.tvalid <= 1'b1;
                m.tdata  <= out_data;
                m.tkeep  <= out_keep;
                m.tid    <= out_tid;
                m.tlast  <= out_last;
            end else if (m.tready) begin
                m.tvalid <= 1'b0;
            end

            if (accept && (state_q != DROP)) begin
                if (state_q == IDLE) mode_q <= enable;
                beat_cnt_q <= beats_now;
                byte_cnt_q <= bytes_now;
            end

            if (out_hs_last) begin
                pkt_seq_q <= pkt_seq_q + 16'd1;
                pkt_count <= pkt_count + 32'd1;
            end

            if (accept && forced_last && (trunc_count != 16'hFFFF)) begin
                trunc_count <= trunc_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rdma_host_trailer_inserter.sv
// Directed bench for rdma_host_trailer_inserter: beat table plus stall and reset sequences.
module tb_rdma_host_trailer_inserter;

    localparam int DW   = 512;
    localparam int KW   = DW / 8;
    localparam int IW   = 6;
    localparam int MAXB = 4;
    localparam logic [KW-1:0] ALL1 = {KW{1'b1}};

    typedef enum logic [1:0] {K_PASS, K_TRL, K_DROP} kind_e;

    typedef struct {
        logic          en;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [IW-1:0] tid;
        logic          last;
        kind_e         kind;
        logic [15:0]   beats;
        logic [15:0]   seq;
        logic [31:0]   bytes;
        logic          err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [IW-1:0] tid;
        logic          last;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] pkt_count;
    logic [15:0] trunc_count;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t  vecs[$];
    beat_t in_q[$];
    beat_t exp_q[$];

    rdma_host_trailer_inserter_if #(.DATA_BITS(DW), .ID_BITS(IW)) s_if ();
    rdma_host_trailer_inserter_if #(.DATA_BITS(DW), .ID_BITS(IW)) m_if ();

    rdma_host_trailer_inserter #(
        .DATA_BITS (DW),
        .ID_BITS   (IW),
        .MAX_BEATS (MAXB)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .enable      (enable),
        .s           (s_if),
        .m           (m_if),
        .pkt_count   (pkt_count),
        .trunc_count (trunc_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] trl(input logic [15:0] beats, input logic [15:0] seq,
                                          input logic [31:0] bytes, input logic err);
        logic [DW-1:0] t;
        t        = '0;
        t[31:0]  = 32'hC0DE_7A11;
        t[47:32] = beats;
        t[63:48] = seq;
        t[95:64] = bytes;
        t[96]    = err;
        return t;
    endfunction

    task automatic add(input logic en, input logic [KW-1:0] keep, input logic [IW-1:0] tid,
                       input logic last, input kind_e kind, input logic [15:0] beats,
                       input logic [15:0] seq, input logic [31:0] bytes, input logic err);
        vec_t v;
        v.en = en; v.data = rnd_data(); v.keep = keep; v.tid = tid; v.last = last;
        v.kind = kind; v.beats = beats; v.seq = seq; v.bytes = bytes; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic drive(input beat_t b, input logic valid);
        s_if.tdata  = b.data;
        s_if.tkeep  = b.keep;
        s_if.tid    = b.tid;
        s_if.tlast  = b.last;
        s_if.tvalid = valid;
    endtask

    initial begin
        logic [DW-1:0] exp_d, held_d;
        logic [KW-1:0] exp_k;
        logic          exp_l;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [71:0]   prev_ctl;
        beat_t         b;
        int            bi, oi;

        s_if.tdata = '0; s_if.tkeep = '0; s_if.tid = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        held_d = '0;

        // Packet A: enable flips low mid-packet and must be ignored.
        add(1, ALL1,  5, 0, K_PASS, 0, 0, 0, 0);
        add(0, ALL1,  5, 0, K_PASS, 0, 0, 0, 0);
        add(0, ALL1,  5, 1, K_TRL,  3, 0, 192, 0);
        // Two back-to-back one-beat packets.
        add(1, 64'hF, 2, 1, K_TRL,  1, 1, 4, 0);
        add(1, 64'hF, 2, 1, K_TRL,  1, 2, 4, 0);
        // Seven beats against MAX_BEATS=4: truncated at beat 4, rest dropped; beat 2 has no bytes.
        add(1, ALL1,  7, 0, K_PASS, 0, 0, 0, 0);
        add(1, '0,    7, 0, K_PASS, 0, 0, 0, 0);
        add(1, ALL1,  7, 0, K_PASS, 0, 0, 0, 0);
        add(1, 64'hFF, 7, 0, K_TRL, 4, 3, 136, 1);
        add(1, ALL1,  7, 0, K_DROP, 0, 0, 0, 0);
        add(1, 64'h3, 7, 0, K_DROP, 0, 0, 0, 0);
        add(1, ALL1,  7, 1, K_DROP, 0, 0, 0, 0);
        // Normal two-beat packet after the drop.
        add(1, 64'hFFFF, 1, 0, K_PASS, 0, 0, 0, 0);
        add(1, 64'h1,    1, 1, K_TRL,  2, 4, 17, 0);
        // Transparent five-beat packet: longer than MAX_BEATS, enable raised mid-packet.
        add(0, 64'h0123_4567_89AB_CDEF, 3, 0, K_PASS, 0, 0, 0, 0);
        add(1, 64'hF0F0,                3, 0, K_PASS, 0, 0, 0, 0);
        add(1, ALL1,                    3, 0, K_PASS, 0, 0, 0, 0);
        add(1, 64'h8000_0000_0000_0001, 3, 0, K_PASS, 0, 0, 0, 0);
        add(1, 64'h7,                   3, 1, K_PASS, 0, 0, 0, 0);

        // Reset state.
        repeat (2) @(posedge aclk);
        #1;
        check("reset m_tvalid", DW'(m_if.tvalid), DW'(1'b0));
        check("reset m_tdata", m_if.tdata, '0);
        check("reset pkt_count", DW'(pkt_count), DW'(0));
        check("reset trunc_count", DW'(trunc_count), DW'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            enable      = vecs[i].en;
            m_if.tready = (vecs[i].kind != K_DROP);
            b.data = vecs[i].data; b.keep = vecs[i].keep; b.tid = vecs[i].tid; b.last = vecs[i].last;
            drive(b, 1'b1);
            if (vecs[i].kind == K_DROP)
                check($sformatf("v%0d drop s_tready", i), DW'(s_if.tready), DW'(1'b1));
            @(posedge aclk);
            #1;
            if (vecs[i].kind == K_DROP) begin
                // The forced last beat stays parked while the dropped beats are swallowed.
                check($sformatf("v%0d held m_tvalid", i), DW'(m_if.tvalid), DW'(1'b1));
                check($sformatf("v%0d held m_tdata", i), m_if.tdata, held_d);
            end else begin
                exp_d = (vecs[i].kind == K_TRL)
                        ? trl(vecs[i].beats, vecs[i].seq, vecs[i].bytes, vecs[i].err) : vecs[i].data;
                exp_k = (vecs[i].kind == K_TRL) ? ALL1 : vecs[i].keep;
                exp_l = (vecs[i].kind == K_TRL) ? 1'b1 : vecs[i].last;
                held_d = exp_d;
                check($sformatf("v%0d m_tvalid", i), DW'(m_if.tvalid), DW'(1'b1));
                check($sformatf("v%0d m_tdata", i), m_if.tdata, exp_d);
                check($sformatf("v%0d m_tkeep", i), DW'(m_if.tkeep), DW'(exp_k));
                check($sformatf("v%0d m_tid", i), DW'(m_if.tid), DW'(vecs[i].tid));
                check($sformatf("v%0d m_tlast", i), DW'(m_if.tlast), DW'(exp_l));
            end
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        @(posedge aclk);
        #1;
        check("table drain m_tvalid", DW'(m_if.tvalid), DW'(1'b0));
        check("table pkt_count", DW'(pkt_count), DW'(6));
        check("table trunc_count", DW'(trunc_count), DW'(1));

        // Fresh reset, then 20 packets under random back-pressure.
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        enable  = 1'b1;
        for (int p = 0; p < 20; p++) begin
            int          len;
            logic [31:0] bytes;
            logic [IW-1:0] tid;
            len   = $urandom_range(1, 4);
            tid   = IW'($urandom);
            bytes = 0;
            for (int j = 0; j < len; j++) begin
                b.data = rnd_data();
                b.keep = ($urandom_range(0, 4) == 0) ? '0 : {$urandom, $urandom};
                b.tid  = tid;
                b.last = (j == len - 1);
                bytes += 32'($countones(b.keep));
                in_q.push_back(b);
                if (b.last) begin
                    b.data = trl(16'(len), 16'(p), bytes, 1'b0);
                    b.keep = ALL1;
                end
                exp_q.push_back(b);
            end
        end

        bi = 0;
        oi = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_ctl   = '0;
        @(posedge aclk);
        #1;
        for (int cyc = 0; cyc < 3000 && (oi < exp_q.size() || bi < in_q.size()); cyc++) begin
            m_if.tready = 1'($urandom_range(0, 1));
            if (bi < in_q.size()) drive(in_q[bi], 1'b1);
            else                  s_if.tvalid = 1'b0;
            @(negedge aclk);
            if (prev_stall) begin
                check("stall m_tdata", m_if.tdata, prev_data);
                check("stall m_ctl", DW'({m_if.tvalid, m_if.tlast, m_if.tid, m_if.tkeep}), DW'(prev_ctl));
            end
            if (m_if.tvalid && m_if.tready) begin
                if (oi < exp_q.size()) begin
                    check($sformatf("s%0d m_tdata", oi), m_if.tdata, exp_q[oi].data);
                    check($sformatf("s%0d m_tkeep", oi), DW'(m_if.tkeep), DW'(exp_q[oi].keep));
                    check($sformatf("s%0d m_tid", oi), DW'(m_if.tid), DW'(exp_q[oi].tid));
                    check($sformatf("s%0d m_tlast", oi), DW'(m_if.tlast), DW'(exp_q[oi].last));
                end else begin
                    check("stream extra beat", DW'(1'b1), DW'(1'b0));
                end
                oi++;
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_ctl   = {m_if.tvalid, m_if.tlast, m_if.tid, m_if.tkeep};
            if (s_if.tvalid && s_if.tready) bi++;
            @(posedge aclk);
            #1;
        end
        if (oi < exp_q.size()) check("stream timeout beats", DW'(oi), DW'(exp_q.size()));
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("stream drain m_tvalid", DW'(m_if.tvalid), DW'(1'b0));
        check("stream pkt_count", DW'(pkt_count), DW'(20));

        // Asynchronous reset in the middle of a packet.
        for (int j = 0; j < 2; j++) begin
            b.data = rnd_data(); b.keep = ALL1; b.tid = 9; b.last = 1'b0;
            drive(b, 1'b1);
            @(posedge aclk);
            #1;
        end
        s_if.tvalid = 1'b0;
        check("pre-reset m_tvalid", DW'(m_if.tvalid), DW'(1'b1));
        #2;
        aresetn = 1'b0;
        #1;
        check("async m_tvalid", DW'(m_if.tvalid), DW'(1'b0));
        check("async m_tdata", m_if.tdata, '0);
        check("async m_tlast", DW'(m_if.tlast), DW'(1'b0));
        check("async pkt_count", DW'(pkt_count), DW'(0));
        check("async trunc_count", DW'(trunc_count), DW'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        b.data = rnd_data(); b.keep = 64'h3; b.tid = 9; b.last = 1'b1;
        drive(b, 1'b1);
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        check("post-reset m_tvalid", DW'(m_if.tvalid), DW'(1'b1));
        check("post-reset trailer", m_if.tdata, trl(16'd1, 16'd0, 32'd2, 1'b0));
        check("post-reset m_tid", DW'(m_if.tid), DW'(6'd9));
        @(posedge aclk);
        #1;
        check("post-reset pkt_count", DW'(pkt_count), DW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rdma_host_trailer_inserter.md
Name: rdma_host_trailer_inserter

Overview:
- Network-to-host datapath in the user logic: accepts the RDMA QSFP0 receive stream (axis_rdma_0_sink) and drives the host card stream (axis_host_src).
- Passes payload beats through unchanged and replaces the data of each packet's last beat with a trailer (magic, beat count, byte count, sequence, error flag).
- Enforces a maximum packet length: an over-long packet is truncated with an error trailer and its remainder is dropped.

Parameters:
- DATA_BITS, 512, stream data width (AXI_DATA_BITS).
- ID_BITS, 6, tid width (PID_BITS).
- MAX_BEATS, 1024, maximum beats per packet including the last beat; range 2..65535.
- TRAILER_MAGIC, 32'hC0DE_7A11, constant placed in trailer bits [31:0].

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  1 = trailer insertion; 0 = transparent pass-through (sampled only in IDLE)
- s_tdata  in  DATA_BITS  sink data
- s_tkeep  in  DATA_BITS/8  sink byte enables
- s_tid  in  ID_BITS  sink id
- s_tlast  in  1  sink last
- s_tvalid  in  1  sink valid
- s_tready  out  1  sink ready
- m_tdata  out  DATA_BITS  source data
- m_tkeep  out  DATA_BITS/8  source byte enables
- m_tid  out  ID_BITS  source id
- m_tlast  out  1  source last
- m_tvalid  out  1  source valid
- m_tready  in  1  source ready
- pkt_count  out  32  packets emitted (wraps)
- trunc_count  out  16  truncated packets (saturates)

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; counters 0; mode latch = 0.
- Output stage:
  - Single registered stage; s_tready = !m_tvalid || m_tready, except in DROP, where s_tready = 1.
  - Latency is 1 cycle; full throughput of 1 beat/cycle under continuous m_tready.
  - m_* are held stable while m_tvalid && !m_tready.
- FSM:
  - IDLE:
    - The first accepted beat latches mode = enable.
    - tlast=1 gives a one-beat packet: emit it, stay in IDLE.
    - Otherwise go to IN_PKT with beat_cnt=1 and byte_cnt=popcount(tkeep).
  - IN_PKT: each accepted beat increments beat_cnt and adds popcount(tkeep) to byte_cnt (32 b).
    - tlast=1: emit beat, go to IDLE.
    - Else if beat_cnt+1 == MAX_BEATS and mode=1: emit the beat as forced last (m_tlast=1), error=1, go to DROP.
    - When mode=0 there is no length limit.
  - DROP: accepted beats are discarded (m_tvalid not asserted). A beat with tlast=1 returns the FSM to IDLE.
- Trailer, on every emitted last beat when mode=1:
  - m_tdata[31:0] = TRAILER_MAGIC
  - [47:32] = beats in packet, including the last
  - [63:48] = pkt_seq
  - [95:64] = bytes, including the last beat's popcount
  - [96] = error
  - all remaining bits 0
  - m_tkeep = all ones; m_tid = packet tid
- Non-last beats: data, keep and tid are passed through unchanged.
- Pass-through (mode=0): data, keep, tid and last are all unchanged.
- Sequence number: pkt_seq (16 b) increments when the last-beat handshake completes on m_*, and wraps 0xFFFF→0.
- pkt_count increments on every emitted last-beat handshake, in both modes.
- trunc_count increments at the forced-last beat and saturates at 0xFFFF.
- A change of enable mid-packet has no effect until the next IDLE.
- An accepted beat with s_tkeep=0 counts as a beat and adds 0 bytes.
- m_tvalid and m_tready are independent of s_tvalid in the same cycle; there is no combinational path from s_tvalid to m_tvalid.

Decomposition:
- Shared package: trailer field offsets (TRL_MAGIC_LSB, TRL_BEATS_LSB, TRL_SEQ_LSB, TRL_BYTES_LSB, TRL_ERR_BIT), TRAILER_MAGIC default, and the FSM state enum (IDLE, IN_PKT, DROP).
- One sub-module: keep_popcount (DATA_BITS/8 → 7 b, combinational adder tree).

Test Plan:
- enable=1, 3-beat packet, all tkeep=FF..FF, tid=5:
  - beats 1–2 pass unchanged.
  - Beat 3 data[31:0]=C0DE7A11, beats=3, seq=0, bytes=192, err=0, m_tlast=1, m_tid=5.
  - pkt_count=1.
- enable=1, one-beat packet with tkeep=0x0F, twice back-to-back:
  - bytes=4 in both trailers.
  - seq=0, then seq=1.
  - No bubble between them with m_tready=1.
- enable=1, MAX_BEATS=4, 7-beat packet:
  - 4 beats emitted; the 4th has m_tlast=1, err=1, beats=4.
  - Beats 5–7 are dropped with s_tready=1.
  - trunc_count=1.
  - A following 2-beat packet is emitted normally.
- enable=0, 5-beat packet with random data:
  - Output is bit-identical to the input.
  - pkt_count increments; no truncation occurs.
- Random m_tready (50%) with a 20-packet stream:
  - No beat is lost or duplicated.
  - m_* are stable while stalled.
  - seq runs 0..19.
- Async reset asserted mid-packet:
  - Outputs and counters go to 0 immediately; state goes to IDLE.
  - The next packet gets seq=0.
